// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int unsigned ILEN             = 32;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries; pointers carry an extra MSB to tell full from empty.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full;

    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Storage is reset too so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // The credit rule upstream guarantees a free slot for every accepted response.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (push && !pop && !flush) |-> !full);

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: credit-limited requests, prefetch buffer, redirect flush.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [31:0]     instr_pc,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, resp_pc_q;
    logic [CW-1:0] outstanding_q, discard_q;

    fetch_entry_t  head, push_data;
    logic [CW-1:0] count;
    logic          fifo_empty, push, pop, grant;
    logic [CW:0]   in_use;
    logic [31:0]   redirect_base;

    always_comb begin
        instr_valid   = !fifo_empty && !redirect;
        pop           = instr_valid && instr_ready;
        // Entries held plus words still owed by memory, net of this cycle's pop.
        in_use        = {1'b0, count} + {1'b0, outstanding_q} - (CW+1)'(pop);
        imem_req      = rst && !redirect && (in_use < DEPTH_C);
        grant         = imem_req && imem_gnt;
        push          = imem_rvalid && (discard_q == '0) && !redirect;
        push_data     = '{pc: resp_pc_q, instr: imem_rdata};
        redirect_base = redirect_pc & 32'hFFFF_FFFC;
        imem_addr     = fetch_pc_q;
        instr         = head.instr;
        instr_pc      = head.pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(grant) - CW'(imem_rvalid);
            if (redirect) begin
                fetch_pc_q <= redirect_base;
                resp_pc_q  <= redirect_base;
                // Every word still owed after this cycle belongs to the old stream.
                discard_q  <= outstanding_q - CW'(imem_rvalid);
            end else begin
                if (grant) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (imem_rvalid && (discard_q != '0)) begin
                    discard_q <= discard_q - CW'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model of variable latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        instr_valid, instr_ready, redirect;
    logic [31:0] instr, instr_pc, redirect_pc;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int lat      = 1;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t mq[$];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Record this cycle's grant, cross the edge, present any due response at the negedge.
    task automatic step();
        logic        g;
        logic [31:0] a;
        g = rst && imem_req && imem_gnt;
        a = imem_addr;
        @(posedge clk);
        if (g) mq.push_back('{due: cyc + lat, addr: a});
        cyc++;
        @(negedge clk);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !instr_valid; i++) begin
            step();
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        #1 rst = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", instr_pc, 0);
        step();
        step();

        // Boot: request in first cycle out of reset, one instruction per cycle from cycle 3.
        rst = 1'b1;
        #1;
        check("boot_req", imem_req, 1);
        check("boot_addr", imem_addr, 32'h0);
        check("boot_valid", instr_valid, 0);
        step(); #1;
        check("c2_valid", instr_valid, 0);
        check("c2_addr", imem_addr, 32'h4);
        step(); #1;
        check("c3_valid", instr_valid, 1);
        check("c3_pc", instr_pc, 32'h0);
        check("c3_instr", instr, mem_word(32'h0));
        for (int k = 1; k <= 5; k++) begin
            step(); #1;
            check("stream_valid", instr_valid, 1);
            check("stream_pc", instr_pc, 32'(4 * k));
            check("stream_instr", instr, mem_word(32'(4 * k)));
        end

        // Stall: buffer fills, requests stop, head holds still.
        step();
        instr_ready = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", instr_valid, 1);
            check("stall_pc", instr_pc, 32'h18);
            check("stall_instr", instr, mem_word(32'h18));
            check("stall_req", imem_req, 0);
            step(); #1;
        end
        instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("resume_valid", instr_valid, 1);
            check("resume_pc", instr_pc, 32'h18 + 32'(4 * k));
            check("resume_instr", instr, mem_word(32'h18 + 32'(4 * k)));
            step(); #1;
        end

        // Drain with grants withheld, then put two requests in flight on a slow memory.
        imem_gnt = 1'b0;
        repeat (4) begin step(); #1; end
        imem_gnt = 1'b1;
        lat = 3;
        #1;
        check("cr_req0", imem_req, 1);
        check("cr_addr0", imem_addr, 32'h30);
        step(); #1;
        check("cr_req1", imem_req, 1);
        step(); #1;
        check("credit_stall", imem_req, 0);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        #1;
        check("redir_valid", instr_valid, 0);
        step();
        redirect = 1'b0;
        #1;
        check("redir_addr", imem_addr, 32'h100);
        wait_valid(20);
        check("redir_first_valid", instr_valid, 1);
        check("redir_first_pc", instr_pc, 32'h100);
        check("redir_first_instr", instr, mem_word(32'h100));

        // Redirect coinciding with a response and a ready head.
        lat = 1;
        repeat (8) begin step(); #1; end
        for (int i = 0; i < 10 && !(instr_valid && imem_rvalid); i++) begin
            step(); #1;
        end
        check("p4_setup", 32'(instr_valid && imem_rvalid), 1);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check("p4_override", instr_valid, 0);
        step();
        redirect = 1'b0;
        #1;
        check("p4_flushed", instr_valid, 0);
        check("p4_addr", imem_addr, 32'h200);
        check("p4_req", imem_req, 1);
        step(); #1;
        check("p4_t2_valid", instr_valid, 0);
        step(); #1;
        check("p4_t3_valid", instr_valid, 1);
        check("p4_t3_pc", instr_pc, 32'h200);
        check("p4_t3_instr", instr, mem_word(32'h200));

        // Address wrap at the top of the space; low redirect bits ignored.
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF9;
        #1;
        step();
        redirect = 1'b0;
        #1;
        check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        wait_valid(10);
        check("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        check("wrap_instr0", instr, mem_word(32'hFFFF_FFF8));
        step(); #1;
        check("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        step(); #1;
        check("wrap_valid2", instr_valid, 1);
        check("wrap_pc2", instr_pc, 32'h0);
        check("wrap_instr2", instr, mem_word(32'h0));

        // Reset mid-stream, memory reset alongside.
        rst = 1'b0;
        mq.delete();
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        #1;
        check("mrst_req", imem_req, 0);
        check("mrst_valid", instr_valid, 0);
        check("mrst_instr", instr, 0);
        check("mrst_pc", instr_pc, 0);
        step();
        rst = 1'b1;
        #1;
        check("reboot_req", imem_req, 1);
        check("reboot_addr", imem_addr, 32'h0);
        wait_valid(10);
        check("reboot_valid", instr_valid, 1);
        check("reboot_pc", instr_pc, 32'h0);
        check("reboot_instr", instr, mem_word(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
